fp_div_seq: RTL and testbench



---
 rtl/fp_div_seq.sv | 146 ++++++++++++++
 tb/tb_fp_div_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: sign XOR, exponent subtract and
// re-bias, and a restoring divider producing MANT_W+2 quotient bits, one per clock.
module fp_div_seq #(
    parameter int BIAS   = 127,
    parameter int MANT_W = 23
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        div_zero
);

    localparam int QW = MANT_W + 2;
    localparam int RW = MANT_W + 3;
    localparam int CW = $clog2(QW);
    localparam logic signed [9:0] E_BIAS = 10'(BIAS);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t                 state;
    logic                   sign;
    logic signed [9:0]      e;
    logic [MANT_W:0]        mb;
    logic [RW-1:0]          r;
    logic [QW-1:0]          q;
    logic [CW-1:0]          count;

    logic [7:0]             ea, eb;
    logic [MANT_W-1:0]      fa, fb;
    logic                   sign_in;
    logic signed [9:0]      e_in;
    logic                   r_ge;
    logic [RW-1:0]          r_sub;
    logic signed [9:0]      e_n;
    logic [MANT_W-1:0]      frac;

    assign ea      = op_a[MANT_W+7:MANT_W];
    assign eb      = op_b[MANT_W+7:MANT_W];
    assign fa      = op_a[MANT_W-1:0];
    assign fb      = op_b[MANT_W-1:0];
    assign sign_in = op_a[31] ^ op_b[31];
    assign e_in    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + E_BIAS;

    // One restoring step: subtract the divisor whenever the partial remainder covers it.
    assign r_ge  = (r >= {2'b00, mb});
    assign r_sub = r_ge ? (r - {2'b00, mb}) : r;

    // A quotient below 1.0 needs one left shift and an exponent decrement.
    always_comb begin
        e_n  = e;
        frac = q[QW-2:1];
        if (!q[QW-1]) begin
            e_n  = e - 10'sd1;
            frac = q[QW-3:0];
        end
    end

    // NOTE: asynchronous reset abandons any operation in flight and clears every
    // visible output, so a reset mid-divide can never produce a done pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            div_zero <= 1'b0;
            sign     <= 1'b0;
            e        <= '0;
            mb       <= '0;
            r        <= '0;
            q        <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign     <= sign_in;
                        e        <= e_in;
                        mb       <= {1'b1, fb};
                        r        <= {2'b00, 1'b1, fa};
                        q        <= '0;
                        count    <= '0;
                        ovf      <= 1'b0;
                        unf      <= 1'b0;
                        div_zero <= 1'b0;
                        // Special operands resolve in this single edge; denormals flush to zero.
                        if (ea == 8'hFF || eb == 8'hFF) begin
                            result <= 32'h7FC0_0000;
                            done   <= 1'b1;
                        end else if (eb == 8'h00) begin
                            result   <= {sign_in, 8'hFF, 23'h0};
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else if (ea == 8'h00) begin
                            result <= {sign_in, 31'h0};
                            done   <= 1'b1;
                        end else begin
                            state <= DIV;
                            busy  <= 1'b1;
                        end
                    end
                end

                DIV: begin
                    r     <= r_sub << 1;
                    q     <= {q[QW-2:0], r_ge};
                    count <= count + 1'b1;
                    if (count == CW'(QW - 1)) begin
                        state <= NORM;
                    end
                end

                NORM: begin
                    if (e_n >= 10'sd255) begin
                        result <= {sign, 8'hFF, 23'h0};
                        ovf    <= 1'b1;
                    end else if (e_n <= 10'sd0) begin
                        result <= {sign, 31'h0};
                        unf    <= 1'b1;
                    end else begin
                        result <= {sign, e_n[7:0], frac};
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases, handshake and reset corners,
// and random operands checked against an arithmetic reference model.
module tb_fp_div_seq;

    logic        CLK   = 1'b0;
    logic        nRST  = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a  = '0;
    logic [31:0] op_b  = '0;
    logic        busy, done, ovf, unf, div_zero;
    logic [31:0] result;

    int n_checks = 0;
    int n_err    = 0;

    fp_div_seq dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf),
        .unf      (unf),
        .div_zero (div_zero)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: quotient as floor(ma * 2^24 / mb), normalised, truncated.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic o,
                                  output logic u, output logic z, output bit special);
        int          xa = int'(a[30:23]);
        int          xb = int'(b[30:23]);
        int          ex;
        logic [63:0] ma, mb, qq;
        logic        s = a[31] ^ b[31];
        o = 1'b0; u = 1'b0; z = 1'b0; special = 1'b1;
        if (xa == 255 || xb == 255) begin
            res = 32'h7FC0_0000;
        end else if (xb == 0) begin
            res = {s, 8'hFF, 23'h0};
            z   = 1'b1;
        end else if (xa == 0) begin
            res = {s, 31'h0};
        end else begin
            special = 1'b0;
            ma = 64'(a[22:0]) + 64'h80_0000;
            mb = 64'(b[22:0]) + 64'h80_0000;
            qq = (ma << 24) / mb;
            ex = xa - xb + 127;
            if (qq < 64'h100_0000) begin
                qq = qq * 2;
                ex = ex - 1;
            end
            if (ex >= 255) begin
                res = {s, 8'hFF, 23'h0};
                o   = 1'b1;
            end else if (ex <= 0) begin
                res = {s, 31'h0};
                u   = 1'b1;
            end else begin
                res = {s, 8'(ex), qq[23:1]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        int          sel = int'($urandom_range(0, 15));
        logic [7:0]  ex;
        logic [31:0] w = $urandom;
        if (sel == 0)      ex = 8'h00;
        else if (sel == 1) ex = 8'hFF;
        else               ex = 8'($urandom_range(1, 254));
        return {w[31], ex, w[22:0]};
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Bounded wait for done; an expired bound shows up as a wrong latency.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge CLK);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eo, eu, ez;
        bit          sp;
        int          cyc, bc;
        model(a, b, er, eo, eu, ez, sp);
        launch(a, b);
        wait_done(cyc, bc);
        check({tag, ".latency"}, 32'(cyc), sp ? 32'd0 : 32'd26);
        check({tag, ".busy_cycles"}, 32'(bc), sp ? 32'd0 : 32'd26);
        check({tag, ".result"}, result, er);
        check({tag, ".ovf"}, 32'(ovf), 32'(eo));
        check({tag, ".unf"}, 32'(unf), 32'(eu));
        check({tag, ".div_zero"}, 32'(div_zero), 32'(ez));
        @(negedge CLK);
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, bc, pulses;
        logic [31:0] seen;

        #1 nRST = 1'b0;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.result", result, 32'h0);
        check("rst.flags", {29'b0, ovf, unf, div_zero}, 32'd0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        run_op("div6_2", 32'h40C0_0000, 32'h4000_0000);
        check("div6_2.lit", result, 32'h4040_0000);
        run_op("div1_3", 32'h3F80_0000, 32'h4040_0000);
        check("div1_3.lit", result, 32'h3EAA_AAAA);
        run_op("neg6_2", 32'hC0C0_0000, 32'h4000_0000);
        check("neg6_2.lit", result, 32'hC040_0000);
        run_op("dz", 32'h3F80_0000, 32'h0000_0000);
        check("dz.lit", result, 32'h7F80_0000);
        run_op("nan", 32'h7FC0_0000, 32'h4000_0000);
        check("nan.lit", result, 32'h7FC0_0000);
        run_op("unf", 32'h0080_0000, 32'h4000_0000);
        check("unf.lit", 32'(unf), 32'd1);
        run_op("ovf", 32'h7F00_0000, 32'h3E80_0000);
        check("ovf.lit", result, 32'h7F80_0000);
        repeat (3) @(negedge CLK);
        check("ovf.held", 32'(ovf), 32'd1);

        // A start at cycle 10 of an operation must be dropped.
        launch(32'h40C0_0000, 32'h4000_0000);
        repeat (9) @(negedge CLK);
        op_a  = 32'h3F80_0000;
        op_b  = 32'h4040_0000;
        start = 1'b1;
        @(negedge CLK);
        start  = 1'b0;
        pulses = 0;
        seen   = '0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                pulses++;
                seen = result;
            end
            @(negedge CLK);
        end
        check("ignore.pulses", 32'(pulses), 32'd1);
        check("ignore.result", seen, 32'h4040_0000);
        check("ignore.idle", 32'(busy), 32'd0);

        // Start during the done cycle launches the next operation at once.
        launch(32'h3F80_0000, 32'h4040_0000);
        wait_done(cyc, bc);
        check("b2b.first", result, 32'h3EAA_AAAA);
        op_a  = 32'hC0C0_0000;
        op_b  = 32'h4000_0000;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check("b2b.busy", 32'(busy), 32'd1);
        check("b2b.held", result, 32'h3EAA_AAAA);
        wait_done(cyc, bc);
        check("b2b.latency", 32'(cyc), 32'd26);
        check("b2b.second", result, 32'hC040_0000);

        for (int i = 0; i < 40; i++) begin
            run_op("rnd", rand_fp(), rand_fp());
        end

        // Reset in the middle of a divide.
        launch(32'h40C0_0000, 32'h4000_0000);
        repeat (11) @(negedge CLK);
        check("mid.busy", 32'(busy), 32'd1);
        #2 nRST = 1'b0;
        #1;
        check("mid.rst_busy", 32'(busy), 32'd0);
        check("mid.rst_done", 32'(done), 32'd0);
        check("mid.rst_result", result, 32'h0);
        check("mid.rst_flags", {29'b0, ovf, unf, div_zero}, 32'd0);
        op_a  = 32'h40C0_0000;
        op_b  = 32'h4000_0000;
        start = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("mid.no_activity", 32'(pulses), 32'd0);
        start = 1'b0;
        nRST  = 1'b1;
        @(negedge CLK);
        check("mid.post_idle", 32'(busy), 32'd0);
        run_op("after_rst", 32'h40C0_0000, 32'h4000_0000);
        check("after_rst.lit", result, 32'h4040_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
